// File: rtl/enc16to4_scan_pkg.sv
// rtl/enc16to4_scan_pkg.sv - shared constants and state type for the 16-to-4 scanning encoder
package enc16to4_scan_pkg;

    localparam int ENC_W = 4;
    localparam int VEC_W = 16;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/enc16to4_scan_if.sv
// rtl/enc16to4_scan_if.sv - request-vector input and index-stream output handshake bundle
interface enc16to4_scan_if;
    import enc16to4_scan_pkg::*;

    logic [VEC_W-1:0] in_vec;
    logic             in_valid;
    logic             in_ready;
    logic [ENC_W-1:0] out_code;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             out_none;

    // Producer of vectors / consumer of codes
    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_code, out_valid, out_last, out_none
    );

    // The encoder itself
    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_code, out_valid, out_last, out_none
    );
endinterface

// File: rtl/enc16to4_scan_priority_enc4to2.sv
// rtl/enc16to4_scan_priority_enc4to2.sv - combinational 4-to-2 priority encoder, lowest index wins
module priority_enc4to2 (
    input  logic [3:0] in,
    output logic [1:0] idx,
    output logic       any
);

    // Lowest set bit wins; idx is 0 when nothing is set
    always_comb begin
        idx = 2'd0;
        any = |in;
        if (in[0])      idx = 2'd0;
        else if (in[1]) idx = 2'd1;
        else if (in[2]) idx = 2'd2;
        else if (in[3]) idx = 2'd3;
    end

endmodule

// File: rtl/enc16to4_scan.sv
// rtl/enc16to4_scan.sv - emits the binary index of every set request bit, one per beat, in priority order
module enc16to4_scan
    import enc16to4_scan_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    enc16to4_scan_if.slave   bus
);

    localparam logic [ENC_W-1:0] MAX_CODE = ENC_W'(VEC_W - 1);

    state_t           state_q, state_d;
    logic [VEC_W-1:0] pending_q, pending_d;
    logic             zero_q, zero_d;

    logic [VEC_W-1:0] scan_vec;
    logic [1:0]       nib_idx [4];
    logic [3:0]       nib_any;
    logic [1:0]       top_idx;
    logic             top_any;
    logic [ENC_W-1:0] raw_code;
    logic [ENC_W-1:0] code;
    logic             at_most_one;

    // MSB-first priority reuses the LSB-first tree on a bit-reversed copy
    always_comb begin
        scan_vec = '0;
        for (int i = 0; i < VEC_W; i++) begin
            scan_vec[i] = LSB_FIRST ? pending_q[i] : pending_q[VEC_W-1-i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_nib
            priority_enc4to2 u_nib (
                .in  (scan_vec[g*4 +: 4]),
                .idx (nib_idx[g]),
                .any (nib_any[g])
            );
        end
    endgenerate

    priority_enc4to2 u_top (
        .in  (nib_any),
        .idx (top_idx),
        .any (top_any)
    );

    // Assemble the code, undo the reversal, and force 0 for an empty vector
    always_comb begin
        raw_code    = {top_idx, nib_idx[top_idx]};
        code        = '0;
        if (top_any) begin
            code = LSB_FIRST ? raw_code : (MAX_CODE - raw_code);
        end
        at_most_one = ((pending_q & (pending_q - VEC_W'(1))) == '0);
    end

    // Outputs depend only on registered state, never on in_* or out_ready
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == EMIT);
        bus.out_code  = (state_q == EMIT) ? code : '0;
        bus.out_last  = (state_q == EMIT) && at_most_one;
        bus.out_none  = (state_q == EMIT) && zero_q;
    end

    // Next-state: capture a vector in IDLE, retire one bit per accepted beat in EMIT
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        zero_d    = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    pending_d = bus.in_vec;
                    zero_d    = (bus.in_vec == '0);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (at_most_one) begin
                        state_d   = IDLE;
                        pending_d = '0;
                        zero_d    = 1'b0;
                    end else begin
                        pending_d = pending_q & ~(VEC_W'(1) << code);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any pending work at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            zero_q    <= zero_d;
        end
    end

endmodule

// File: tb/tb_enc16to4_scan.sv
// tb/tb_enc16to4_scan.sv - directed self-checking bench for both priority orders of enc16to4_scan
module tb_enc16to4_scan;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    enc16to4_scan_if if_l ();
    enc16to4_scan_if if_m ();

    enc16to4_scan #(.LSB_FIRST(1'b1)) dut_l (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_l.slave)
    );

    enc16to4_scan #(.LSB_FIRST(1'b0)) dut_m (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_m.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] vec, input logic valid, input logic ready);
        if_l.in_vec    = vec;
        if_l.in_valid  = valid;
        if_l.out_ready = ready;
        if_m.in_vec    = vec;
        if_m.in_valid  = valid;
        if_m.out_ready = ready;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check one beat on both instances: valid, codes, last, none, in_ready low
    task automatic beat(input string tag, input logic [3:0] code_l, input logic [3:0] code_m,
                        input logic last, input logic none);
        chk({tag, " valid_l"}, 16'(if_l.out_valid), 16'd1);
        chk({tag, " valid_m"}, 16'(if_m.out_valid), 16'd1);
        chk({tag, " code_l"},  16'(if_l.out_code),  16'(code_l));
        chk({tag, " code_m"},  16'(if_m.out_code),  16'(code_m));
        chk({tag, " last_l"},  16'(if_l.out_last),  16'(last));
        chk({tag, " last_m"},  16'(if_m.out_last),  16'(last));
        chk({tag, " none_l"},  16'(if_l.out_none),  16'(none));
        chk({tag, " none_m"},  16'(if_m.out_none),  16'(none));
        chk({tag, " in_ready_l"}, 16'(if_l.in_ready), 16'd0);
    endtask

    task automatic idle(input string tag);
        chk({tag, " idle in_ready_l"},  16'(if_l.in_ready),  16'd1);
        chk({tag, " idle in_ready_m"},  16'(if_m.in_ready),  16'd1);
        chk({tag, " idle out_valid_l"}, 16'(if_l.out_valid), 16'd0);
        chk({tag, " idle out_valid_m"}, 16'(if_m.out_valid), 16'd0);
    endtask

    initial begin
        int beats;
        int cycles;
        logic r;

        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(16'h0000, 1'b0, 1'b0);
        step();
        step();

        // Reset state
        idle("reset");
        chk("reset out_code", 16'(if_l.out_code), 16'd0);
        chk("reset out_last", 16'(if_l.out_last), 16'd0);
        chk("reset out_none", 16'(if_l.out_none), 16'd0);
        rst_n = 1'b1;
        step();

        // Single bit 5: one beat, then IDLE
        drive(16'h0020, 1'b1, 1'b1);
        step();
        beat("h0020", 4'd5, 4'd5, 1'b1, 1'b0);
        drive(16'h0000, 1'b0, 1'b1);
        step();
        idle("h0020");

        // Three bits: order depends on priority direction
        drive(16'h8101, 1'b1, 1'b1);
        step();
        beat("h8101 b0", 4'd0, 4'd15, 1'b0, 1'b0);
        drive(16'h0000, 1'b0, 1'b1);
        step();
        beat("h8101 b1", 4'd8, 4'd8, 1'b0, 1'b0);
        step();
        beat("h8101 b2", 4'd15, 4'd0, 1'b1, 1'b0);
        step();
        idle("h8101");

        // Zero vector: one none beat
        drive(16'h0000, 1'b1, 1'b1);
        step();
        beat("zero", 4'd0, 4'd0, 1'b1, 1'b1);
        drive(16'h0000, 1'b0, 1'b1);
        step();
        idle("zero");

        // Stall: outputs hold, in_vec changes are ignored while emitting
        drive(16'h0006, 1'b1, 1'b0);
        step();
        drive(16'hFFFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            beat("stall", 4'd1, 4'd2, 1'b0, 1'b0);
            step();
        end
        beat("stall end", 4'd1, 4'd2, 1'b0, 1'b0);
        drive(16'h0000, 1'b0, 1'b1);
        step();
        beat("h0006 b1", 4'd2, 4'd1, 1'b1, 1'b0);
        step();
        idle("h0006");

        // All ones under random back-pressure
        drive(16'hFFFF, 1'b1, 1'b0);
        step();
        beats  = 0;
        cycles = 0;
        while (beats < 16 && cycles < 400) begin
            r = 1'($urandom_range(0, 1));
            drive(16'h0000, 1'b0, r);
            if (if_l.out_valid && r) begin
                beat("ffff", 4'(beats), 4'(15 - beats), (beats == 15), 1'b0);
                beats++;
            end
            step();
            cycles++;
        end
        chk("ffff beat count", 16'(beats), 16'd16);
        idle("ffff");

        // Asynchronous reset in the middle of h00F0
        drive(16'h00F0, 1'b1, 1'b1);
        step();
        beat("h00f0 b0", 4'd4, 4'd7, 1'b0, 1'b0);
        drive(16'h0000, 1'b0, 1'b1);
        step();
        beat("h00f0 b1", 4'd5, 4'd6, 1'b0, 1'b0);
        drive(16'h0000, 1'b0, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst out_valid_l", 16'(if_l.out_valid), 16'd0);
        chk("async rst out_valid_m", 16'(if_m.out_valid), 16'd0);
        step();
        rst_n = 1'b1;
        step();
        idle("post reset");
        drive(16'h0001, 1'b1, 1'b1);
        step();
        beat("h0001", 4'd0, 4'd0, 1'b1, 1'b0);
        drive(16'h0000, 1'b0, 1'b1);
        step();
        idle("h0001");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enc16to4_scan.md
Name: enc16to4_scan

Overview:
- Sequential counterpart to the team's 4-to-16 binary decoder.
- Accepts a 16-bit request vector (one-hot or multi-hot) and emits the 4-bit binary index of every set bit, one per output handshake, in priority order.
- Sits between a bank of request/flag lines and any consumer that needs binary indices, e.g. one that drives the 4-to-16 decoder to acknowledge each line.
- Priority resolution is built hierarchically from 4-to-2 priority encoders, mirroring the decoder's 2-to-4 tree.

Parameters:
- LSB_FIRST, 1: 1 gives bit 0 the highest priority; 0 gives bit 15 the highest priority.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_vec  input  16  request vector; sampled only on an input handshake.
- in_valid  input  1  in_vec valid.
- in_ready  output  1  block can accept a vector.
- out_code  output  4  binary index of the current highest-priority pending bit.
- out_valid  output  1  out_code valid.
- out_ready  input  1  consumer accepts out_code.
- out_last  output  1  this beat is the final beat for the current vector.
- out_none  output  1  the accepted vector was all zeros; out_code is 0.

Behaviour:
- Clocking and reset
  - One clock domain, clk; asynchronous active-low reset, rst_n.
  - Reset values: state IDLE, pending=16'h0000, in_ready=1, out_valid=0, out_code=0, out_last=0, out_none=0.
  - Reset asserted mid-operation discards pending bits immediately. No further output beats; the block is ready again after reset release.
- State IDLE
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a clk edge: pending<=in_vec, zero_flag<=(in_vec==0), go to EMIT.
- State EMIT
  - in_ready=0, out_valid=1.
  - All outputs are functions of registered state only, so there are no combinational paths from in_* or out_ready to any output.
  - out_code = index of the highest-priority set bit of pending, per LSB_FIRST.
  - out_last = 1 when pending has at most one bit set.
  - out_none = zero_flag.
  - On out_valid&&out_ready:
    - If out_last, go to IDLE and clear pending/zero_flag.
    - Otherwise clear bit out_code of pending and stay in EMIT.
  - Without out_ready, all outputs hold stable; out_valid must not drop before its handshake.
- Latency and throughput
  - The first beat is valid the cycle after input acceptance.
  - A vector with N set bits (N>=1) produces N beats in N cycles under continuous out_ready.
  - The next vector can be accepted the cycle after the last beat. Total N+1 cycles per vector.
- Boundary conditions
  - Zero vector: exactly one beat with out_none=1, out_code=0, out_last=1.
  - in_vec=16'hFFFF: 16 beats, codes 0..15 (LSB_FIRST=1) or 15..0 (LSB_FIRST=0), out_last only on the 16th.
  - in_vec changing while in EMIT is ignored; in_valid held high is accepted only when back in IDLE.
- Priority logic
  - Four priority_enc4to2 instances, one per nibble, produce a per-nibble any flag and 2-bit index.
  - A fifth instance selects the winning nibble from the any flags.
  - out_code = {nibble_idx, bit_idx}.
  - For LSB_FIRST=0 the same tree runs on bit-reversed inputs, and the code is then converted to 15-code.
- Popcount
  - out_last uses a "pending & (pending-1) == 0" test; no counter is required.

Decomposition:
- Shared package holds:
  - ENC_W=4 and VEC_W=16 constants.
  - State enum {IDLE, EMIT}.
- Sub-module: priority_enc4to2.
  - Inputs: 4-bit in.
  - Outputs: 2-bit idx and any.
  - Purely combinational, lowest index wins.
  - Reused five times.

Test Plan:
- Reset then in_vec=16'h0020 with in_valid=1 and out_ready=1 -> next cycle out_valid=1, out_code=5, out_last=1, out_none=0; IDLE the following cycle with in_ready=1.
- in_vec=16'h8101, out_ready=1, LSB_FIRST=1 -> codes 0, 8, 15 on consecutive cycles, out_last only with 15; repeat with LSB_FIRST=0 -> codes 15, 8, 0.
- in_vec=16'h0000 -> single beat out_none=1, out_code=0, out_last=1.
- in_vec=16'h0006 with out_ready low for 3 cycles -> out_code=1 held stable with out_valid=1; on the ready pulse it advances to 2 with out_last=1; in_ready stays 0 throughout.
- in_vec=16'hFFFF with random out_ready -> exactly 16 beats, codes strictly ascending, no duplicates or drops.
- rst_n pulsed low mid-stream after the 2nd beat of 16'h00F0 -> out_valid=0 asynchronously, in_ready=1 after release, and a new vector 16'h0001 yields code 0 only.
